ladybird_bus_rr_arbiter: RTL and testbench

LADYBIRD_BUS_RR_ARBITER -- requirements
Module: ladybird_bus_rr_arbiter

---
 rtl/ladybird_bus_rr_arbiter_if.sv | 40 ++++
 rtl/ladybird_bus_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_ladybird_bus_rr_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ladybird_bus_rr_arbiter_if.sv
// Bus bundle between N requesters, the round-robin arbiter and one downstream port.
// master: the arbiter's view (it masters the downstream port and answers requesters).
// slave:  the surrounding system's view (requesters plus downstream target).
interface ladybird_bus_rr_arbiter_if #(
  parameter int N_INPUT = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32
);
  // Requester side, packed per requester (requester i at slice i)
  logic [N_INPUT-1:0]          in_req;
  logic [N_INPUT*ADDR_W-1:0]   in_addr;
  logic [N_INPUT*DATA_W/8-1:0] in_wstrb;
  logic [N_INPUT*DATA_W-1:0]   in_wdata;
  logic [N_INPUT-1:0]          in_gnt;
  logic [N_INPUT-1:0]          in_data_gnt;
  logic [DATA_W-1:0]           in_rdata;

  // Downstream side
  logic                        out_req;
  logic [ADDR_W-1:0]           out_addr;
  logic [DATA_W/8-1:0]         out_wstrb;
  logic [DATA_W-1:0]           out_wdata;
  logic                        out_gnt;
  logic                        out_data_gnt;
  logic [DATA_W-1:0]           out_rdata;

  modport master (
    input  in_req, in_addr, in_wstrb, in_wdata,
    output in_gnt, in_data_gnt, in_rdata,
    output out_req, out_addr, out_wstrb, out_wdata,
    input  out_gnt, out_data_gnt, out_rdata
  );

  modport slave (
    output in_req, in_addr, in_wstrb, in_wdata,
    input  in_gnt, in_data_gnt, in_rdata,
    input  out_req, out_addr, out_wstrb, out_wdata,
    output out_gnt, out_data_gnt, out_rdata
  );
endinterface

// File: rtl/ladybird_bus_rr_arbiter.sv
// Round-robin arbiter merging N request/grant ports onto one downstream port.
// Granted requester IDs are queued in a small FIFO so each out_data_gnt is
// routed back to the right requester in acceptance order. Reads (wstrb==0)
// and writes (wstrb!=0) are handled identically: both get one data grant.
module ladybird_bus_rr_arbiter #(
  parameter int N_INPUT = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      arst,
  ladybird_bus_rr_arbiter_if.master bus,
  output logic                      err
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // Round-robin priority pointer and ID FIFO state
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             err_reg, err_next;
  logic [IDX_W-1:0] id_mem [DEPTH];

  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] head;
  logic             found;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // (base + k) mod N_INPUT, with k < N_INPUT so one subtraction suffices
  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_INPUT) s = s - N_INPUT;
    return IDX_W'(s);
  endfunction

  // Pick the first requesting index at or after the priority pointer
  always_comb begin
    sel   = ptr_reg;
    found = 1'b0;
    for (int k = 0; k < N_INPUT; k++) begin
      if (!found && bus.in_req[rot_idx(ptr_reg, k)]) begin
        sel   = rot_idx(ptr_reg, k);
        found = 1'b1;
      end
    end
  end

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  // Full blocks new requests even if a pop frees a slot this same cycle
  assign bus.out_req   = (|bus.in_req) && !full;
  assign bus.out_addr  = bus.in_addr [int'(sel)*ADDR_W +: ADDR_W];
  assign bus.out_wstrb = bus.in_wstrb[int'(sel)*STRB_W +: STRB_W];
  assign bus.out_wdata = bus.in_wdata[int'(sel)*DATA_W +: DATA_W];

  assign push = bus.out_req && bus.out_gnt;
  assign pop  = bus.out_data_gnt && !empty;

  // Oldest outstanding ID; read combinationally since the data grant is same-cycle
  assign head = id_mem[rd_ptr_reg];

  // Read data is broadcast; only the requester with in_data_gnt consumes it
  assign bus.in_rdata = bus.out_rdata;
  assign err          = err_reg;

  for (genvar gi = 0; gi < N_INPUT; gi++) begin : g_req
    assign bus.in_gnt[gi]      = push && (sel  == IDX_W'(gi));
    assign bus.in_data_gnt[gi] = pop  && (head == IDX_W'(gi));
  end

  // Next-state for pointers, occupancy and sticky error
  always_comb begin
    ptr_next    = ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    err_next    = err_reg;
    if (push) begin
      ptr_next    = rot_idx(sel, 1);
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    if (push && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!push && pop) begin
      count_next = count_reg - CNT_W'(1);
    end
    // A data grant with nothing outstanding is a downstream protocol violation
    if (bus.out_data_gnt && empty) begin
      err_next = 1'b1;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ptr_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      ptr_reg    <= ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      err_reg    <= err_next;
    end
  end

  // ID storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr_reg] <= sel;
    end
  end
endmodule

// File: tb/tb_ladybird_bus_rr_arbiter.sv
// Directed scoreboard bench for ladybird_bus_rr_arbiter (N_INPUT=2, DEPTH=4).
// Each stimulus row pushes its hand-computed expectations into queues; a
// negedge monitor pops and compares whenever the DUT grants or returns data.
module tb_ladybird_bus_rr_arbiter;
  localparam int N_INPUT = 2;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int DEPTH   = 4;

  localparam logic [31:0] ADDR0  = 32'h1000_0040;
  localparam logic [31:0] ADDR1  = 32'h2000_0080;
  localparam logic [31:0] WDATA0 = 32'hCAFE_0000;
  localparam logic [31:0] WDATA1 = 32'hBEEF_1111;
  localparam logic [3:0]  WSTRB0 = 4'hF;   // requester 0 writes
  localparam logic [3:0]  WSTRB1 = 4'h0;   // requester 1 reads

  typedef struct packed {
    logic [1:0]  gnt;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } gnt_exp_t;

  typedef struct packed {
    logic [1:0]  dgnt;
    logic [31:0] rdata;
  } dat_exp_t;

  typedef struct packed {
    logic out_req;
    logic err;
  } st_exp_t;

  logic clk = 1'b0;
  logic arst;
  logic err;

  int vectors     = 0;
  int miscompares = 0;

  gnt_exp_t gnt_q[$];
  dat_exp_t dat_q[$];
  st_exp_t  st_q[$];

  gnt_exp_t ge_m;
  dat_exp_t de_m;
  st_exp_t  se_m;

  ladybird_bus_rr_arbiter_if #(.N_INPUT(N_INPUT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ladybird_bus_rr_arbiter #(
    .N_INPUT(N_INPUT), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .arst(arst),
    .bus (bus),
    .err (err)
  );

  always #5 clk = ~clk;

  // One cycle: drive inputs just after the rising edge and queue expectations
  task automatic apply(input logic r, input logic [1:0] req, input logic og, input logic odg,
                       input logic [31:0] rd, input logic [1:0] eg, input logic [1:0] edg,
                       input logic eor, input logic eerr);
    gnt_exp_t ge;
    dat_exp_t de;
    st_exp_t  se;
    @(posedge clk);
    #1;
    arst             = r;
    bus.in_req       = req;
    bus.out_gnt      = og;
    bus.out_data_gnt = odg;
    bus.out_rdata    = rd;
    if (eg != 2'b00) begin
      ge.gnt   = eg;
      ge.addr  = eg[1] ? ADDR1  : ADDR0;
      ge.wstrb = eg[1] ? WSTRB1 : WSTRB0;
      ge.wdata = eg[1] ? WDATA1 : WDATA0;
      gnt_q.push_back(ge);
    end
    if (edg != 2'b00) begin
      de.dgnt  = edg;
      de.rdata = rd;
      dat_q.push_back(de);
    end
    se.out_req = eor;
    se.err     = eerr;
    st_q.push_back(se);
  endtask

  // Monitor: compare status every cycle, grants and responses as they appear
  always @(negedge clk) begin
    if (st_q.size() > 0) begin
      se_m = st_q.pop_front();
      vectors++;
      if (bus.out_req !== se_m.out_req) begin
        miscompares++;
        $display("FAIL out_req got=%b exp=%b t=%0t", bus.out_req, se_m.out_req, $time);
      end
      vectors++;
      if (err !== se_m.err) begin
        miscompares++;
        $display("FAIL err got=%b exp=%b t=%0t", err, se_m.err, $time);
      end
    end
    if (bus.in_gnt !== 2'b00) begin
      vectors++;
      if (gnt_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_gnt got=%b exp=none t=%0t", bus.in_gnt, $time);
      end else begin
        ge_m = gnt_q.pop_front();
        if (bus.in_gnt !== ge_m.gnt || bus.out_addr !== ge_m.addr ||
            bus.out_wstrb !== ge_m.wstrb || bus.out_wdata !== ge_m.wdata) begin
          miscompares++;
          $display("FAIL grant got=%b/%h/%h/%h exp=%b/%h/%h/%h t=%0t",
                   bus.in_gnt, bus.out_addr, bus.out_wstrb, bus.out_wdata,
                   ge_m.gnt, ge_m.addr, ge_m.wstrb, ge_m.wdata, $time);
        end else begin
          $display("grant   in_gnt=%b addr=%h wstrb=%h t=%0t", bus.in_gnt, bus.out_addr, bus.out_wstrb, $time);
        end
      end
    end
    if (bus.in_data_gnt !== 2'b00) begin
      vectors++;
      if (dat_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_data_gnt got=%b exp=none t=%0t", bus.in_data_gnt, $time);
      end else begin
        de_m = dat_q.pop_front();
        if (bus.in_data_gnt !== de_m.dgnt || bus.in_rdata !== de_m.rdata) begin
          miscompares++;
          $display("FAIL response got=%b/%h exp=%b/%h t=%0t",
                   bus.in_data_gnt, bus.in_rdata, de_m.dgnt, de_m.rdata, $time);
        end else begin
          $display("response in_data_gnt=%b rdata=%h t=%0t", bus.in_data_gnt, bus.in_rdata, $time);
        end
      end
    end
  end

  initial begin
    arst             = 1'b1;
    bus.in_req       = '0;
    bus.in_addr      = {ADDR1, ADDR0};
    bus.in_wstrb     = {WSTRB1, WSTRB0};
    bus.in_wdata     = {WDATA1, WDATA0};
    bus.out_gnt      = 1'b0;
    bus.out_data_gnt = 1'b0;
    bus.out_rdata    = '0;

    //     rst  req    og    odg   rdata         eg     edg    eor   err
    // Reset state; out_req follows in_req from the reset state
    apply(1'b1, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 1'b0);
    apply(1'b1, 2'b01, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b1, 1'b0);
    // Single requester, response two cycles after grant
    apply(1'b0, 2'b01, 1'b1, 1'b0, 32'h0,        2'b01, 2'b00, 1'b1, 1'b0);
    apply(1'b0, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 1'b0);
    apply(1'b0, 2'b00, 1'b0, 1'b1, 32'h63,       2'b00, 2'b01, 1'b0, 1'b0);
    apply(1'b1, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 1'b0);
    // Contention from ptr=0, filling the FIFO
    apply(1'b0, 2'b11, 1'b1, 1'b0, 32'h0,        2'b01, 2'b00, 1'b1, 1'b0);
    apply(1'b0, 2'b11, 1'b1, 1'b0, 32'h0,        2'b10, 2'b00, 1'b1, 1'b0);
    apply(1'b0, 2'b11, 1'b1, 1'b0, 32'h0,        2'b01, 2'b00, 1'b1, 1'b0);
    apply(1'b0, 2'b11, 1'b1, 1'b0, 32'h0,        2'b10, 2'b00, 1'b1, 1'b0);
    // Full: no request even with a same-cycle pop; request returns next cycle
    apply(1'b0, 2'b11, 1'b1, 1'b1, 32'hA0,       2'b00, 2'b01, 1'b0, 1'b0);
    apply(1'b0, 2'b11, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b1, 1'b0);
    apply(1'b0, 2'b00, 1'b0, 1'b1, 32'hA1,       2'b00, 2'b10, 1'b0, 1'b0);
    apply(1'b0, 2'b00, 1'b0, 1'b1, 32'hA2,       2'b00, 2'b01, 1'b0, 1'b0);
    apply(1'b0, 2'b00, 1'b0, 1'b1, 32'hA3,       2'b00, 2'b10, 1'b0, 1'b0);
    // Ordering: grants 1,0,1 then delayed responses
    apply(1'b0, 2'b10, 1'b1, 1'b0, 32'h0,        2'b10, 2'b00, 1'b1, 1'b0);
    apply(1'b0, 2'b01, 1'b1, 1'b0, 32'h0,        2'b01, 2'b00, 1'b1, 1'b0);
    apply(1'b0, 2'b10, 1'b1, 1'b0, 32'h0,        2'b10, 2'b00, 1'b1, 1'b0);
    apply(1'b0, 2'b00, 1'b0, 1'b1, 32'h11,       2'b00, 2'b10, 1'b0, 1'b0);
    apply(1'b0, 2'b00, 1'b0, 1'b1, 32'h22,       2'b00, 2'b01, 1'b0, 1'b0);
    apply(1'b0, 2'b00, 1'b0, 1'b1, 32'h33,       2'b00, 2'b10, 1'b0, 1'b0);
    // Rotation: ptr=0 picks 0, then ptr=1 picks 1
    apply(1'b0, 2'b11, 1'b1, 1'b0, 32'h0,        2'b01, 2'b00, 1'b1, 1'b0);
    apply(1'b0, 2'b11, 1'b1, 1'b0, 32'h0,        2'b10, 2'b00, 1'b1, 1'b0);
    apply(1'b0, 2'b00, 1'b0, 1'b1, 32'h44,       2'b00, 2'b01, 1'b0, 1'b0);
    apply(1'b0, 2'b00, 1'b0, 1'b1, 32'h55,       2'b00, 2'b10, 1'b0, 1'b0);
    // Simultaneous push and pop
    apply(1'b0, 2'b01, 1'b1, 1'b0, 32'h0,        2'b01, 2'b00, 1'b1, 1'b0);
    apply(1'b0, 2'b01, 1'b1, 1'b1, 32'h66,       2'b01, 2'b01, 1'b1, 1'b0);
    apply(1'b0, 2'b00, 1'b0, 1'b1, 32'h77,       2'b00, 2'b01, 1'b0, 1'b0);
    // Data grant on empty FIFO (with a same-cycle push) sets sticky err
    apply(1'b0, 2'b01, 1'b1, 1'b1, 32'hEE,       2'b01, 2'b00, 1'b1, 1'b0);
    apply(1'b0, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 1'b1);
    apply(1'b0, 2'b00, 1'b0, 1'b1, 32'h88,       2'b00, 2'b01, 1'b0, 1'b1);
    apply(1'b1, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 1'b0);
    // Reset mid-operation discards the outstanding ID
    apply(1'b0, 2'b10, 1'b1, 1'b0, 32'h0,        2'b10, 2'b00, 1'b1, 1'b0);
    apply(1'b1, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 1'b0);
    apply(1'b0, 2'b00, 1'b0, 1'b1, 32'hDD,       2'b00, 2'b00, 1'b0, 1'b0);
    apply(1'b0, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 1'b1);
    apply(1'b1, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 1'b0);
    // After reset ptr is back at 0
    apply(1'b0, 2'b11, 1'b1, 1'b0, 32'h0,        2'b01, 2'b00, 1'b1, 1'b0);
    apply(1'b0, 2'b00, 1'b0, 1'b1, 32'h99,       2'b00, 2'b01, 1'b0, 1'b0);
    apply(1'b0, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 1'b0);

    // Let the monitor drain the last row, then every expectation must be consumed
    @(posedge clk);
    @(posedge clk);
    vectors++;
    if (gnt_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_grants got=%0d_left exp=0", gnt_q.size());
    end
    vectors++;
    if (dat_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_responses got=%0d_left exp=0", dat_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
